csa: RTL and testbench
======================

CSA -- requirements
Module: csa

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the number of independent bit-slices.
REQ-002 The port list SHALL have positional order s, c, w, a, b, r, clk, so parent designs can connect ports by position.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 r  input  1  reset; SHALL be synchronous and active-low.
REQ-005 s  output  WIDTH  registered sum bit(s).
REQ-006 c  output  WIDTH  registered carry bit(s), not shifted.
REQ-007 w  input  WIDTH  addend 0, typically a coefficient/weight bit.
REQ-008 a  input  WIDTH  addend 1, typically a shifted data or feedback sum bit.
REQ-009 b  input  WIDTH  addend 2, typically a broadcast bit or feedback carry bit.

Function
REQ-010 Each slice i SHALL be a 3:2 compressor (full adder) over w[i], a[i] and b[i].
REQ-011 The next-state sum SHALL be w[i] XOR a[i] XOR b[i].
REQ-012 The next-state carry SHALL be the majority of the three inputs: (w&a)|(w&b)|(a&b).
REQ-013 s and c SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled at edge k appear on s/c after edge k and hold until edge k+1.
REQ-015 Slices SHALL be fully independent; there SHALL be no carry propagation between slices.
REQ-016 c[i] SHALL have the same weight as input bit i; any shift by one position is done by the parent.
REQ-017 Outputs SHALL update every cycle when not in reset; there is no enable and no hold state.
REQ-018 Feedback of s/c into a/b by the parent SHALL be legal, because the registered outputs break the loop.
REQ-019 Input combinations with any arithmetic sum 0..3 are all valid; there are no illegal input states.
REQ-020 The synthesised result SHALL have 2*WIDTH flip-flops and no latches.

Reset
REQ-021 When r=0 at a rising clk edge, s and c SHALL both load all-zeros, regardless of w, a and b.
REQ-022 Reset SHALL take priority over the adder update in the same cycle.
REQ-023 Asserting reset mid-operation SHALL clear s and c at the next edge; any in-flight result SHALL be discarded.
REQ-024 A change in r between clock edges SHALL NOT affect s or c (no asynchronous path).
REQ-025 After r returns to 1, the first edge SHALL register the adder result of the inputs present at that edge.
REQ-026 Before the first clock edge, the outputs SHALL be treated as unknown; a bench SHALL apply at least one reset edge first.

Verification
REQ-027 Reset: preload s=1, c=1 (w=a=b=1), then r=0 with w=a=b=1 for one edge -> s=0, c=0.
REQ-028 Exhaustive, WIDTH=1, r=1: for each {w,a,b} of 000..111, after one edge {c,s} = 00,01,01,10,01,10,10,11 respectively.
REQ-029 Latency: switch inputs from 111 to 000 midway between edges -> s=1, c=1 holds until the next edge, then becomes s=0, c=0.
REQ-030 Feedback loop: connect a<=s and b<=c externally, set w=1 for 3 edges -> (s,c) sequence (1,0),(0,1),(0,1).
REQ-031 WIDTH=4: w=4'b1010, a=4'b0110, b=4'b1100, then one edge -> s=4'b0000, c=4'b1110.
REQ-032 Reset pulse: r low for exactly 1 edge, then high, with inputs 011 -> s=0, c=0 after the reset edge, then c=1, s=0 one edge later.

Source files
------------

// File: rtl/csa_if.sv
// Three-operand input / sum-carry output bundle for the registered 3:2 compressor.
interface csa_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;

  modport master (output w, a, b, input s, c);
  modport slave  (input w, a, b, output s, c);
endinterface

// File: rtl/csa.sv
// Registered carry-save adder: WIDTH independent full-adder slices, sum and
// unshifted carry both flopped, synchronous active-low reset.
module csa_core #(
  parameter int WIDTH = 1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  csa_if.slave   bus
);
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;

  always_comb begin
    s_d = bus.w ^ bus.a ^ bus.b;
    c_d = (bus.w & bus.a) | (bus.w & bus.b) | (bus.a & bus.b);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign bus.s = s_q;
  assign bus.c = c_q;
endmodule

// Outer ports keep the legacy positional order so existing parents still connect by position.
module csa #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             r,
  input  logic             clk
);
  csa_if #(.WIDTH(WIDTH)) bus ();

  assign bus.w = w;
  assign bus.a = a;
  assign bus.b = b;
  assign s     = bus.s;
  assign c     = bus.c;

  csa_core #(.WIDTH(WIDTH)) u_core (
    .clk_i  (clk),
    .rst_ni (r),
    .bus    (bus.slave)
  );
endmodule

// File: tb/tb_csa.sv
// Self-checking bench for csa: 1-bit and 4-bit instances, vector table plus
// hand-written reset, latency and feedback sequences.
module tb_csa;
  typedef struct {
    string      name;
    logic [3:0] s;
    logic [3:0] c;
  } exp_t;

  typedef struct {
    logic [2:0] wab;
    logic       s1, c1;
    logic [3:0] w4, a4, b4;
    logic [3:0] s4, c4;
  } vec_t;

  logic clk = 1'b0;
  logic r;
  logic fb;
  logic w1, a1d, b1d;
  int   checks = 0;
  int   errors = 0;
  exp_t sb1[$];
  exp_t sb4[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  csa_if #(.WIDTH(1)) b1 ();
  csa_if #(.WIDTH(4)) b4 ();

  // Feedback mode routes the registered sum/carry of the 1-bit DUT back to a/b.
  assign b1.w = w1;
  assign b1.a = fb ? b1.s : a1d;
  assign b1.b = fb ? b1.c : b1d;

  csa #(.WIDTH(1)) dut1 (
    .s(b1.s), .c(b1.c), .w(b1.w), .a(b1.a), .b(b1.b), .r(r), .clk(clk)
  );

  csa #(.WIDTH(4)) dut4 (
    .s(b4.s), .c(b4.c), .w(b4.w), .a(b4.a), .b(b4.b), .r(r), .clk(clk)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push1(input string name, input logic s, input logic c);
    exp_t e;
    e.name = name; e.s = {3'b000, s}; e.c = {3'b000, c};
    sb1.push_back(e);
  endtask

  task automatic push4(input string name, input logic [3:0] s, input logic [3:0] c);
    exp_t e;
    e.name = name; e.s = s; e.c = c;
    sb4.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check({e.name, ".s1"}, {3'b000, b1.s}, e.s);
      check({e.name, ".c1"}, {3'b000, b1.c}, e.c);
    end
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      check({e.name, ".s4"}, b4.s, e.s);
      check({e.name, ".c4"}, b4.c, e.c);
    end
  endtask

  task automatic drive1(input logic rv, input logic [2:0] wab);
    r = rv;
    {w1, a1d, b1d} = wab;
  endtask

  task automatic drive4(input logic [3:0] w, input logic [3:0] a, input logic [3:0] b);
    b4.w = w; b4.a = a; b4.b = b;
  endtask

  initial begin
    tbl[0] = '{3'b000, 1'b0, 1'b0, 4'b1010, 4'b0110, 4'b1100, 4'b0000, 4'b1110};
    tbl[1] = '{3'b001, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0101, 4'b1010, 4'b0101};
    tbl[2] = '{3'b010, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    tbl[3] = '{3'b011, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[4] = '{3'b100, 1'b1, 1'b0, 4'b1001, 4'b0011, 4'b0101, 4'b1111, 4'b0001};
    tbl[5] = '{3'b101, 1'b0, 1'b1, 4'b0111, 4'b1011, 4'b1101, 4'b0001, 4'b1111};
    tbl[6] = '{3'b110, 1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0001, 4'b0111, 4'b1000};
    tbl[7] = '{3'b111, 1'b1, 1'b1, 4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b0101};

    fb = 1'b0;
    drive1(1'b0, 3'b111);
    drive4(4'hF, 4'hF, 4'hF);
    push1("reset0", 1'b0, 1'b0);
    push4("reset0", 4'h0, 4'h0);
    step();

    // Preload ones, then a reset edge with all inputs high must clear.
    @(negedge clk);
    drive1(1'b1, 3'b111);
    push1("preload", 1'b1, 1'b1);
    push4("preload", 4'hF, 4'hF);
    step();
    @(negedge clk);
    drive1(1'b0, 3'b111);
    push1("rst_prio", 1'b0, 1'b0);
    push4("rst_prio", 4'h0, 4'h0);
    step();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive1(1'b1, tbl[i].wab);
      drive4(tbl[i].w4, tbl[i].a4, tbl[i].b4);
      push1($sformatf("vec%0d", i), tbl[i].s1, tbl[i].c1);
      push4($sformatf("vec%0d", i), tbl[i].s4, tbl[i].c4);
      step();
    end

    // Mid-cycle input and reset changes must not reach the outputs.
    @(negedge clk);
    drive1(1'b1, 3'b111);
    push1("lat_load", 1'b1, 1'b1);
    step();
    @(negedge clk);
    drive1(1'b1, 3'b000);
    #1;
    check("lat_hold.s1", {3'b000, b1.s}, 4'b0001);
    check("lat_hold.c1", {3'b000, b1.c}, 4'b0001);
    r = 1'b0;
    #1;
    check("async_r.s1", {3'b000, b1.s}, 4'b0001);
    check("async_r.c1", {3'b000, b1.c}, 4'b0001);
    r = 1'b1;
    push1("lat_next", 1'b0, 1'b0);
    step();

    @(negedge clk);
    w1 = 1'b1;
    fb = 1'b1;
    push1("fb1", 1'b1, 1'b0);
    step();
    push1("fb2", 1'b0, 1'b1);
    step();
    push1("fb3", 1'b0, 1'b1);
    step();
    @(negedge clk);
    fb = 1'b0;

    // One-edge reset pulse, then the first edge after release adds 0+1+1.
    drive1(1'b0, 3'b011);
    drive4(4'b1010, 4'b0110, 4'b1100);
    push1("pulse_rst", 1'b0, 1'b0);
    push4("pulse_rst", 4'h0, 4'h0);
    step();
    @(negedge clk);
    drive1(1'b1, 3'b011);
    push1("pulse_rel", 1'b0, 1'b1);
    push4("pulse_rel", 4'b0000, 4'b1110);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
